// File: rtl/atm_txn_engine_if.sv
// Controller-facing signal bundle for the ATM transaction engine.
// The controller/bench drives through master; the engine receives through slave.
interface atm_txn_engine_if #(
  parameter int unsigned ACCT_W = 3,
  parameter int unsigned AMT_W  = 16,
  parameter int unsigned BAL_W  = 24
);
  logic              stored_done;
  logic [ACCT_W-1:0] acct_id;
  logic              amount_valid;
  logic [AMT_W-1:0]  amount;
  logic              deposite_selected;
  logic              withdraw_selected;
  logic              update_balance;
  logic              txn_clear;
  logic              pin_restart;
  logic              day_tick;
  logic              Amount_entered;
  logic              Valid_Transaction;
  logic [1:0]        err_code;
  logic [BAL_W-1:0]  balance;
  logic              commit_done;

  modport master (
    output stored_done, acct_id, amount_valid, amount, deposite_selected,
           withdraw_selected, update_balance, txn_clear, pin_restart, day_tick,
    input  Amount_entered, Valid_Transaction, err_code, balance, commit_done
  );

  modport slave (
    input  stored_done, acct_id, amount_valid, amount, deposite_selected,
           withdraw_selected, update_balance, txn_clear, pin_restart, day_tick,
    output Amount_entered, Valid_Transaction, err_code, balance, commit_done
  );
endinterface

// File: rtl/atm_txn_engine.sv
// ATM transaction datapath: per-account balances and daily withdrawal totals,
// amount validation, and a single balance commit per verified transaction.
module atm_txn_engine #(
  parameter int unsigned NUM_ACCTS    = 8,
  parameter int unsigned ACCT_W       = 3,
  parameter int unsigned AMT_W        = 16,
  parameter int unsigned BAL_W        = 24,
  parameter int unsigned INIT_BALANCE = 1000,
  parameter int unsigned MAX_DEPOSIT  = 10000,
  parameter int unsigned DAILY_LIMIT  = 20000,
  parameter int unsigned UNIT_LOG2    = 4
) (
  input logic               clk,
  input logic               rst_n,
  atm_txn_engine_if.slave   bus
);

  localparam int unsigned BW1 = BAL_W + 1;
  localparam int unsigned DW  = AMT_W + 1;
  localparam int unsigned DW1 = AMT_W + 2;

  localparam logic [BAL_W-1:0] InitBal  = BAL_W'(INIT_BALANCE);
  localparam logic [BAL_W:0]   BalMax   = {1'b0, {BAL_W{1'b1}}};
  localparam logic [AMT_W-1:0] MaxDep   = AMT_W'(MAX_DEPOSIT);
  localparam logic [DW1-1:0]   DailyLim = DW1'(DAILY_LIMIT);

  typedef enum logic [2:0] {
    StIdle,
    StSession,
    StCheck,
    StHold,
    StCommit
  } state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [ACCT_W-1:0] r_sess_acct;
  logic [ACCT_W-1:0] w_sess_d;
  logic [AMT_W-1:0]  r_amt;
  logic              r_is_wd;
  logic              r_valid;
  logic [1:0]        r_err;
  logic              r_commit_done;
  logic [BAL_W-1:0]  r_balance;
  logic [BAL_W-1:0]  r_bal   [NUM_ACCTS];
  logic [DW-1:0]     r_daily [NUM_ACCTS];

  logic              w_acct_ok;
  logic              w_one_sel;
  logic [BAL_W-1:0]  w_bal_sess;
  logic [DW-1:0]     w_daily_sess;
  logic [BAL_W:0]    w_amt_wide;
  logic [BAL_W:0]    w_dep_sum;
  logic [DW1-1:0]    w_wd_daily;
  logic [DW-1:0]     w_daily_sat;
  logic [1:0]        w_err;

  assign w_acct_ok    = (32'(bus.acct_id) < NUM_ACCTS);
  assign w_one_sel    = bus.deposite_selected ^ bus.withdraw_selected;
  assign w_bal_sess   = r_bal[r_sess_acct];
  assign w_daily_sess = r_daily[r_sess_acct];
  assign w_amt_wide   = BW1'(r_amt);
  assign w_dep_sum    = {1'b0, w_bal_sess} + w_amt_wide;
  assign w_wd_daily   = {1'b0, w_daily_sess} + DW1'(r_amt);
  assign w_daily_sat  = w_wd_daily[DW1-1] ? {DW{1'b1}} : w_wd_daily[DW-1:0];

  // Check rules; all sums carry one extra bit so nothing wraps.
  always_comb begin
    w_err = 2'd0;
    if (!r_is_wd) begin
      if ((r_amt == '0) || (r_amt > MaxDep) || (w_dep_sum > BalMax)) begin
        w_err = 2'd1;
      end
    end else if ((r_amt == '0) || (r_amt[UNIT_LOG2-1:0] != '0) || (w_wd_daily > DailyLim)) begin
      w_err = 2'd3;
    end else if (w_amt_wide > {1'b0, w_bal_sess}) begin
      w_err = 2'd2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (bus.stored_done && w_acct_ok) begin
          w_state_d = StSession;
        end
      end
      StSession: begin
        if (bus.amount_valid && w_one_sel) begin
          w_state_d = StCheck;
        end
      end
      StCheck: begin
        w_state_d = StHold;
      end
      StHold: begin
        if (bus.update_balance && r_valid) begin
          w_state_d = StCommit;
        end else if (bus.txn_clear) begin
          w_state_d = StSession;
        end
      end
      StCommit: begin
        w_state_d = StSession;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
    // Session end wins over everything; a COMMIT in flight still writes.
    if (bus.pin_restart) begin
      w_state_d = StIdle;
    end
  end

  always_comb begin
    w_sess_d = r_sess_acct;
    if ((r_state == StIdle) && (w_state_d == StSession)) begin
      w_sess_d = bus.acct_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sess_acct   <= '0;
      r_amt         <= '0;
      r_is_wd       <= 1'b0;
      r_valid       <= 1'b0;
      r_err         <= 2'd0;
      r_commit_done <= 1'b0;
      r_balance     <= '0;
    end else begin
      r_sess_acct   <= w_sess_d;
      r_commit_done <= (r_state == StCommit);
      if ((r_state == StSession) && (w_state_d == StCheck)) begin
        r_amt   <= bus.amount;
        r_is_wd <= bus.withdraw_selected;
      end
      if ((w_state_d == StIdle) || (w_state_d == StSession)) begin
        r_valid <= 1'b0;
        r_err   <= 2'd0;
      end else if (r_state == StCheck) begin
        r_valid <= (w_err == 2'd0);
        r_err   <= w_err;
      end
      // Reads the pre-commit array, so a write shows up two edges after HOLD.
      r_balance <= (w_state_d == StIdle) ? '0 : r_bal[w_sess_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_ACCTS); i++) begin
        r_bal[i]   <= InitBal;
        r_daily[i] <= '0;
      end
    end else begin
      if (bus.day_tick) begin
        for (int i = 0; i < int'(NUM_ACCTS); i++) begin
          r_daily[i] <= '0;
        end
      end
      if (r_state == StCommit) begin
        if (r_is_wd) begin
          r_bal[r_sess_acct]   <= w_bal_sess - BAL_W'(r_amt);
          r_daily[r_sess_acct] <= bus.day_tick ? DW'(r_amt) : w_daily_sat;
        end else begin
          r_bal[r_sess_acct] <= w_dep_sum[BAL_W-1:0];
        end
      end
    end
  end

  assign bus.Amount_entered    = (r_state == StCheck) || (r_state == StHold);
  assign bus.Valid_Transaction = r_valid;
  assign bus.err_code          = r_err;
  assign bus.balance           = r_balance;
  assign bus.commit_done       = r_commit_done;

endmodule

// File: tb/tb_atm_txn_engine.sv
// Directed-vector bench for atm_txn_engine with hand-computed expectations.
module tb_atm_txn_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   pulses;

  always #5 clk = ~clk;

  atm_txn_engine_if u_if ();

  atm_txn_engine u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic login(input logic [2:0] acct);
    u_if.pin_restart = 1'b1;
    step();
    u_if.pin_restart = 1'b0;
    u_if.stored_done = 1'b1;
    u_if.acct_id     = acct;
    step();
    u_if.stored_done = 1'b0;
  endtask

  // Strobe an amount and advance through CHECK; ends in HOLD.
  task automatic enter(input bit wd, input logic [15:0] amt);
    u_if.deposite_selected = !wd;
    u_if.withdraw_selected = wd;
    u_if.amount            = amt;
    u_if.amount_valid      = 1'b1;
    step();
    u_if.amount_valid = 1'b0;
    step();
  endtask

  task automatic commit(output int n);
    n = 0;
    u_if.update_balance = 1'b1;
    repeat (5) begin
      step();
      if (u_if.commit_done === 1'b1) n++;
    end
    u_if.update_balance = 1'b0;
  endtask

  task automatic clear_txn();
    u_if.txn_clear = 1'b1;
    step();
    u_if.txn_clear = 1'b0;
  endtask

  initial begin
    u_if.stored_done       = 1'b0;
    u_if.acct_id           = '0;
    u_if.amount_valid      = 1'b0;
    u_if.amount            = '0;
    u_if.deposite_selected = 1'b0;
    u_if.withdraw_selected = 1'b0;
    u_if.update_balance    = 1'b0;
    u_if.txn_clear         = 1'b0;
    u_if.pin_restart       = 1'b0;
    u_if.day_tick          = 1'b0;

    #12;
    chk("rst_ae", 32'(u_if.Amount_entered), 0);
    chk("rst_vt", 32'(u_if.Valid_Transaction), 0);
    chk("rst_err", 32'(u_if.err_code), 0);
    chk("rst_bal", 32'(u_if.balance), 0);
    chk("rst_cd", 32'(u_if.commit_done), 0);
    rst_n = 1'b1;

    login(3'd2);
    chk("login2_bal", 32'(u_if.balance), 1000);

    // Both selects high: strobe ignored
    u_if.deposite_selected = 1'b1;
    u_if.withdraw_selected = 1'b1;
    u_if.amount            = 16'd100;
    u_if.amount_valid      = 1'b1;
    step();
    u_if.amount_valid = 1'b0;
    chk("both_sel_ae", 32'(u_if.Amount_entered), 0);

    // Deposit 500 with explicit latency checks
    u_if.deposite_selected = 1'b1;
    u_if.withdraw_selected = 1'b0;
    u_if.amount            = 16'd500;
    u_if.amount_valid      = 1'b1;
    step();
    u_if.amount_valid = 1'b0;
    chk("dep500_ae_check", 32'(u_if.Amount_entered), 1);
    chk("dep500_vt_check", 32'(u_if.Valid_Transaction), 0);
    step();
    chk("dep500_ae_hold", 32'(u_if.Amount_entered), 1);
    chk("dep500_vt", 32'(u_if.Valid_Transaction), 1);
    chk("dep500_err", 32'(u_if.err_code), 0);
    commit(pulses);
    chk("dep500_pulses", 32'(pulses), 1);
    chk("dep500_bal", 32'(u_if.balance), 1500);
    chk("dep500_ae_after", 32'(u_if.Amount_entered), 0);
    chk("dep500_vt_after", 32'(u_if.Valid_Transaction), 0);

    // Insufficient funds: update_balance ignored
    enter(1'b1, 16'd2000);
    chk("wd2000_vt", 32'(u_if.Valid_Transaction), 0);
    chk("wd2000_err", 32'(u_if.err_code), 2);
    u_if.update_balance = 1'b1;
    pulses = 0;
    repeat (3) begin
      step();
      if (u_if.commit_done === 1'b1) pulses++;
    end
    u_if.update_balance = 1'b0;
    chk("wd2000_pulses", 32'(pulses), 0);
    chk("wd2000_ae_hold", 32'(u_if.Amount_entered), 1);
    clear_txn();
    chk("clr_ae", 32'(u_if.Amount_entered), 0);
    chk("clr_err", 32'(u_if.err_code), 0);
    chk("clr_bal", 32'(u_if.balance), 1500);

    enter(1'b1, 16'd24);
    chk("wd24_err", 32'(u_if.err_code), 3);
    clear_txn();
    enter(1'b0, 16'd0);
    chk("dep0_err", 32'(u_if.err_code), 1);
    clear_txn();
    enter(1'b0, 16'd10001);
    chk("dep10001_err", 32'(u_if.err_code), 1);
    clear_txn();

    enter(1'b0, 16'd10000);
    chk("dep10000_vt", 32'(u_if.Valid_Transaction), 1);
    commit(pulses);
    chk("dep10000_bal", 32'(u_if.balance), 11500);
    enter(1'b0, 16'd10000);
    commit(pulses);
    enter(1'b0, 16'd8500);
    commit(pulses);
    chk("bal30000", 32'(u_if.balance), 30000);

    // Daily limit and day_tick
    enter(1'b1, 16'd16000);
    chk("wd16k_a_vt", 32'(u_if.Valid_Transaction), 1);
    commit(pulses);
    chk("wd16k_a_bal", 32'(u_if.balance), 14000);
    enter(1'b0, 16'd10000);
    commit(pulses);
    enter(1'b1, 16'd16000);
    chk("wd16k_b_err", 32'(u_if.err_code), 3);
    clear_txn();
    u_if.day_tick = 1'b1;
    step();
    u_if.day_tick = 1'b0;
    enter(1'b1, 16'd16000);
    chk("wd16k_c_err", 32'(u_if.err_code), 0);
    commit(pulses);
    chk("wd16k_c_pulses", 32'(pulses), 1);
    chk("wd16k_c_bal", 32'(u_if.balance), 8000);
    enter(1'b1, 16'd4000);
    chk("wd_at_limit_vt", 32'(u_if.Valid_Transaction), 1);
    commit(pulses);
    chk("wd_at_limit_bal", 32'(u_if.balance), 4000);
    enter(1'b1, 16'd16);
    chk("wd_over_limit_err", 32'(u_if.err_code), 3);
    clear_txn();

    // pin_restart in HOLD
    enter(1'b0, 16'd100);
    u_if.pin_restart = 1'b1;
    step();
    u_if.pin_restart = 1'b0;
    chk("pin_ae", 32'(u_if.Amount_entered), 0);
    chk("pin_vt", 32'(u_if.Valid_Transaction), 0);
    chk("pin_bal_idle", 32'(u_if.balance), 0);
    login(3'd2);
    chk("pin_bal_kept", 32'(u_if.balance), 4000);

    // day_tick coinciding with a withdraw-16 commit on account 5
    login(3'd5);
    chk("login5_bal", 32'(u_if.balance), 1000);
    enter(1'b1, 16'd16);
    u_if.update_balance = 1'b1;
    step();
    u_if.day_tick = 1'b1;
    step();
    u_if.day_tick       = 1'b0;
    u_if.update_balance = 1'b0;
    chk("tick_commit_cd", 32'(u_if.commit_done), 1);
    step();
    chk("tick_commit_cd_off", 32'(u_if.commit_done), 0);
    chk("tick_commit_bal", 32'(u_if.balance), 984);
    enter(1'b1, 16'd20000);
    chk("tick_daily_nonzero", 32'(u_if.err_code), 3);
    clear_txn();
    enter(1'b1, 16'd19984);
    chk("tick_daily_is16", 32'(u_if.err_code), 2);
    clear_txn();

    // Reset mid-HOLD
    login(3'd2);
    enter(1'b0, 16'd100);
    chk("prerst_vt", 32'(u_if.Valid_Transaction), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ae", 32'(u_if.Amount_entered), 0);
    chk("midrst_vt", 32'(u_if.Valid_Transaction), 0);
    chk("midrst_bal", 32'(u_if.balance), 0);
    rst_n = 1'b1;
    login(3'd2);
    chk("postrst_bal2", 32'(u_if.balance), 1000);
    login(3'd5);
    chk("postrst_bal5", 32'(u_if.balance), 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
